aes_addkey_pipe: RTL and testbench
==================================

Name: aes_addkey_pipe

Overview:
Parametrised AddRoundKey stage for the AES datapath, supporting AES-128, AES-192 and AES-256 through the NR parameter.
- XORs each accepted state word with the cipher key (round 0) or the scheduled round key (rounds 1..NR).
- Tracks the round index internally and tags each result with its round number and a last flag.
- Buffers results in a DEPTH-entry output FIFO with valid/ready backpressure on both sides.
- Sits between the MixColumns/ShiftRows stage and the round feedback mux / cipher output.

Parameters:
DATA_W, 128, state and key width in bits (multiple of 32).
NR, 10, number of rounds: 10, 12 or 14.
DEPTH, 2, output FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
in_valid  in  1  upstream state word valid
in_ready  out  1  stage can accept a word this cycle
in_data  in  DATA_W  state word
cipher_key  in  DATA_W  cipher key, used for round 0
round_key  in  DATA_W  key-schedule output for the current round
key_valid  in  1  round_key is valid for the current round
flush  in  1  synchronous abort: clear FIFO and round counter
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts the head
out_data  out  DATA_W  head data (XOR result)
out_round  out  4  head round index, 0..NR
out_last  out  1  head is round NR
done  out  1  one-cycle pulse when a round-NR entry is popped
busy  out  1  round counter != 0 or FIFO non-empty

Behaviour:
Reset (rst low, asynchronous):
- FIFO emptied; rnd = 0.
- out_valid, out_data, out_round, out_last, done = 0.
- in_ready = 1 and busy = 0 once reset is released.

Readiness and acceptance:
- in_ready = (count < DEPTH) && (rnd == 0 || key_valid) && !flush.
- in_ready has no combinational path from out_ready. A full FIFO refuses input even in a cycle where it pops.
- Accept (push) = in_valid && in_ready.
- Pushed entry: data = in_data ^ (rnd == 0 ? cipher_key : round_key); round tag = rnd; last = (rnd == NR).

Round counter:
- On each push, rnd increments; when rnd == NR it wraps to 0 instead.
- The next accepted word therefore starts a new block and uses cipher_key.

Output side:
- Latency: a word accepted in cycle N appears at the FIFO head (out_valid = 1) in cycle N+1 if the FIFO was empty.
- Pop = out_valid && out_ready. The head advances on the next edge.
- out_* outputs are driven from registered FIFO storage (registered outputs, no combinational XOR on the output path).
- Simultaneous push and pop with count between 1 and DEPTH-1: count unchanged; order preserved.
- With out_ready held high and key_valid high, throughput is 1 word per cycle.
- done is registered: it is 1 in the cycle after a pop whose entry had last = 1; otherwise 0.

Stalls and errors:
- key_valid low while rnd != 0: in_ready = 0 and rnd holds. No partial or garbage entry is pushed.
- An out_ready toggle while out_valid = 0 has no effect.
- Pointers wrap modulo DEPTH. count is DEPTH+1-state wide and never exceeds DEPTH. There is no overflow or underflow path, because push is gated by count and pop by out_valid.

flush:
- Highest priority over push and pop in the same cycle.
- Next edge: count = 0, pointers = 0, rnd = 0, out_valid = 0, done = 0.
- in_ready = 0 during the flush cycle.

Asynchronous reset mid-block: same state as power-on reset. The partial block is discarded.

NR outside {10, 12, 14}: elaboration error.

Test Plan:
1. Reset state: hold rst low, then release it -> out_valid = 0, out_data = 0, out_round = 0, done = 0, busy = 0, in_ready = 1.
2. FIPS-197 round 0: in_data = 00112233445566778899aabbccddeeff, cipher_key = 000102030405060708090a0b0c0d0e0f, out_ready = 1 -> in the next cycle out_data = 00102030405060708090a0b0c0d0e0f0, out_round = 0, out_last = 0.
3. Full block, NR = 10, continuous valid, key_valid = 1 -> 11 outputs with out_round 0..10; out_last only on round 10; done pulses once, one cycle after that pop; the 12th input uses cipher_key and gets out_round = 0.
4. Backpressure: out_ready = 0 for 4 cycles with in_valid = 1 -> exactly DEPTH = 2 words accepted, then in_ready = 0; on release the words drain in order with correct data and round tags, no loss or duplication.
5. Key stall: key_valid = 0 at rnd = 3 for 3 cycles -> in_ready = 0 and rnd holds at 3; on key_valid = 1 the next output has out_round = 3 and data = in_data ^ round_key.
6. flush at rnd = 6 with 2 entries queued, asserted together with in_valid and out_ready -> no push and no pop; next cycle out_valid = 0, busy = 0, and the next accepted word uses cipher_key with out_round = 0. Repeat test 3 with NR = 14 -> 15 outputs, last flag on round 14.

Source files
------------

// File: rtl/aes_addkey_pipe_if.sv
// Handshake bundle for the AddRoundKey stage: upstream state/key inputs,
// downstream FIFO head and status.
interface aes_addkey_pipe_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] cipher_key;
    logic [DATA_W-1:0] round_key;
    logic              key_valid;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_round;
    logic              out_last;
    logic              done;
    logic              busy;

    modport master (
        output in_valid, in_data, cipher_key, round_key, key_valid, flush, out_ready,
        input  in_ready, out_valid, out_data, out_round, out_last, done, busy
    );

    modport slave (
        input  in_valid, in_data, cipher_key, round_key, key_valid, flush, out_ready,
        output in_ready, out_valid, out_data, out_round, out_last, done, busy
    );
endinterface

// File: rtl/aes_addkey_pipe.sv
// AES AddRoundKey stage: XORs each state word with the cipher/round key,
// tags it with its round index and queues it in a small output FIFO.
module aes_addkey_pipe #(
    parameter int DATA_W = 128,
    parameter int NR     = 10,
    parameter int DEPTH  = 2
) (
    input  logic             clk,
    input  logic             rst,
    aes_addkey_pipe_if.slave bus
);
    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $error("aes_addkey_pipe: NR must be 10, 12 or 14");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("aes_addkey_pipe: DEPTH must be a power of two >= 2");
        end
        if (DATA_W % 32 != 0) begin : g_bad_width
            $error("aes_addkey_pipe: DATA_W must be a multiple of 32");
        end
    endgenerate

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [3:0]        r_tag  [DEPTH];
    logic [DEPTH-1:0]  r_last;
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [3:0]        r_rnd;
    logic              r_done;

    logic              w_full, w_empty, w_round0, w_is_last, w_push, w_pop;
    logic [DATA_W-1:0] w_sum;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_round0  = (r_rnd == 4'd0);
    assign w_is_last = (r_rnd == 4'(NR));

    // Gated only by local state, so in_ready never depends on out_ready.
    assign bus.in_ready = !w_full && (w_round0 || bus.key_valid) && !bus.flush;
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_pop        = !w_empty && bus.out_ready;
    assign w_sum        = bus.in_data ^ (w_round0 ? bus.cipher_key : bus.round_key);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_last <= '0;
        end else if (w_push) begin
            r_data[r_wr_ptr] <= w_sum;
            r_tag[r_wr_ptr]  <= r_rnd;
            r_last[r_wr_ptr] <= w_is_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rnd    <= '0;
            r_done   <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rnd    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_pop && r_last[r_rd_ptr];
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_rnd    <= w_is_last ? 4'd0 : r_rnd + 4'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = r_data[r_rd_ptr];
    assign bus.out_round = r_tag[r_rd_ptr];
    assign bus.out_last  = r_last[r_rd_ptr];
    assign bus.done      = r_done;
    assign bus.busy      = !w_round0 || !w_empty;
endmodule

// File: tb/tb_aes_addkey_pipe.sv
// Bench for aes_addkey_pipe: NR=10 and NR=14 instances share one stimulus
// stream and are each compared every cycle against a queue-based model.
module tb_aes_addkey_pipe;
    localparam int DW    = 128;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, key_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0, cipher_key = '0, round_key = '0;

    always #5 clk = ~clk;

    aes_addkey_pipe_if #(.DATA_W(DW)) bi10 ();
    aes_addkey_pipe_if #(.DATA_W(DW)) bi14 ();

    assign bi10.in_valid = in_valid;   assign bi14.in_valid = in_valid;
    assign bi10.in_data = in_data;     assign bi14.in_data = in_data;
    assign bi10.cipher_key = cipher_key; assign bi14.cipher_key = cipher_key;
    assign bi10.round_key = round_key; assign bi14.round_key = round_key;
    assign bi10.key_valid = key_valid; assign bi14.key_valid = key_valid;
    assign bi10.flush = flush;         assign bi14.flush = flush;
    assign bi10.out_ready = out_ready; assign bi14.out_ready = out_ready;

    aes_addkey_pipe #(.DATA_W(DW), .NR(10), .DEPTH(DEPTH)) dut10 (.clk(clk), .rst(rst), .bus(bi10));
    aes_addkey_pipe #(.DATA_W(DW), .NR(14), .DEPTH(DEPTH)) dut14 (.clk(clk), .rst(rst), .bus(bi14));

    logic [1:0]    ir, ov, ol, od, ob;
    logic [DW-1:0] odat [2];
    logic [3:0]    ornd [2];
    assign ir = {bi14.in_ready, bi10.in_ready};
    assign ov = {bi14.out_valid, bi10.out_valid};
    assign ol = {bi14.out_last, bi10.out_last};
    assign od = {bi14.done, bi10.done};
    assign ob = {bi14.busy, bi10.busy};
    assign odat[0] = bi10.out_data;  assign odat[1] = bi14.out_data;
    assign ornd[0] = bi10.out_round; assign ornd[1] = bi14.out_round;

    typedef struct {
        logic [DW-1:0] d;
        int            r;
        bit            l;
    } ent_t;

    ent_t mq [2][$];
    int   mrnd [2];
    bit   mdone [2];
    bit   mir [2];
    int   obs [2][$];
    int   dcnt [2];
    int   acc [2];
    int   n_chk = 0, n_pass = 0;

    function automatic int nr(input int m);
        return (m == 0) ? 10 : 14;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int obs_at(input int m, input int i);
        return (i < obs[m].size()) ? obs[m][i] : -1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            string p = $sformatf("nr%0d", nr(m));
            bit    ev = (mq[m].size() > 0);
            mir[m] = (mq[m].size() < DEPTH) && (mrnd[m] == 0 || key_valid) && !flush;
            chk({p, ".in_ready"}, 128'(ir[m]), 128'(mir[m]));
            chk({p, ".out_valid"}, 128'(ov[m]), 128'(ev));
            chk({p, ".done"}, 128'(od[m]), 128'(mdone[m]));
            chk({p, ".busy"}, 128'(ob[m]), 128'(mrnd[m] != 0 || ev));
            if (ev) begin
                chk({p, ".out_data"}, odat[m], mq[m][0].d);
                chk({p, ".out_round"}, 128'(ornd[m]), 128'(mq[m][0].r));
                chk({p, ".out_last"}, 128'(ol[m]), 128'(mq[m][0].l));
            end
            if (ov[m] && out_ready && !flush) obs[m].push_back(int'(ornd[m]));
            if (od[m]) dcnt[m]++;
            if (ir[m] && in_valid) acc[m]++;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (flush) begin
                mq[m].delete();
                mrnd[m]  = 0;
                mdone[m] = 1'b0;
            end else begin
                bit   pop  = (mq[m].size() > 0) && out_ready;
                bit   push = in_valid && mir[m];
                ent_t e;
                mdone[m] = pop && mq[m][0].l;
                if (pop) void'(mq[m].pop_front());
                if (push) begin
                    e.d = in_data ^ ((mrnd[m] == 0) ? cipher_key : round_key);
                    e.r = mrnd[m];
                    e.l = (mrnd[m] == nr(m));
                    mq[m].push_back(e);
                    mrnd[m] = (mrnd[m] == nr(m)) ? 0 : mrnd[m] + 1;
                end
            end
        end
    endtask

    // Inputs are set at the falling edge; outputs sampled 1 unit later.
    task automatic cyc();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("nr%0d.rst_out_valid", nr(m)), 128'(ov[m]), 128'(0));
            chk($sformatf("nr%0d.rst_out_data", nr(m)), odat[m], 128'(0));
            chk($sformatf("nr%0d.rst_out_round", nr(m)), 128'(ornd[m]), 128'(0));
            chk($sformatf("nr%0d.rst_done", nr(m)), 128'(od[m]), 128'(0));
            chk($sformatf("nr%0d.rst_busy", nr(m)), 128'(ob[m]), 128'(0));
            mq[m].delete();
            mrnd[m]  = 0;
            mdone[m] = 1'b0;
        end
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        for (int m = 0; m < 2; m++) begin
            obs[m].delete();
            dcnt[m] = 0;
            acc[m]  = 0;
        end
    endtask

    task automatic drive_rand();
        in_data    = rnd128();
        cipher_key = rnd128();
        round_key  = rnd128();
    endtask

    initial begin
        // reset state and FIPS-197 round-0 vector
        do_reset();
        clear_obs();
        in_valid   = 1'b1;
        key_valid  = 1'b1;
        out_ready  = 1'b1;
        in_data    = 128'h00112233445566778899aabbccddeeff;
        cipher_key = 128'h000102030405060708090a0b0c0d0e0f;
        round_key  = rnd128();
        cyc();
        in_valid = 1'b0;
        #1;
        chk("fips_data", odat[0], 128'h00102030405060708090a0b0c0d0e0f0);
        chk("fips_round", 128'(ornd[0]), 128'(0));
        chk("fips_last", 128'(ol[0]), 128'(0));
        cyc();
        cyc();

        // full blocks at full throughput
        do_reset();
        clear_obs();
        in_valid = 1'b1; key_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_rand();
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("nr%0d.blk_pops", nr(m)), 128'(obs[m].size()), 128'(16));
            chk($sformatf("nr%0d.blk_done", nr(m)), 128'(dcnt[m]), 128'(1));
            for (int i = 0; i < 16; i++)
                chk($sformatf("nr%0d.blk_round%0d", nr(m), i), 128'(obs_at(m, i)), 128'(i % (nr(m) + 1)));
        end

        // backpressure
        do_reset();
        clear_obs();
        out_ready = 1'b0; in_valid = 1'b1; key_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            cyc();
        end
        chk("bp_accepted", 128'(acc[0]), 128'(DEPTH));
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("bp_drained", 128'(obs[0].size()), 128'(DEPTH));
        chk("bp_order0", 128'(obs_at(0, 0)), 128'(0));
        chk("bp_order1", 128'(obs_at(0, 1)), 128'(1));

        // key stall at round 3
        do_reset();
        clear_obs();
        out_ready = 1'b1; in_valid = 1'b1; key_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cyc();
        end
        key_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cyc();
        end
        chk("stall_acc", 128'(acc[0]), 128'(3));
        key_valid = 1'b1;
        drive_rand();
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("stall_round", 128'(obs_at(0, 3)), 128'(3));

        // flush with two entries queued at round 6
        do_reset();
        clear_obs();
        out_ready = 1'b1; in_valid = 1'b1; key_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            cyc();
        end
        out_ready = 1'b0;
        drive_rand();
        cyc();
        chk("fl_queued", 128'(acc[0]), 128'(6));
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        drive_rand();
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_out_valid", 128'(ov[0]), 128'(0));
        chk("fl_busy", 128'(ob[0]), 128'(0));
        cyc();
        in_valid = 1'b1;
        drive_rand();
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("fl_restart_round", 128'(obs_at(0, obs[0].size() - 1)), 128'(0));

        // random traffic with an asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            in_valid  = ($urandom_range(3) != 0);
            key_valid = ($urandom_range(7) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(49) == 0);
            drive_rand();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
